hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised successor to the combinational hazard detector of the five-stage MIPS core.
- Replaces fixed lw/beq pattern matching with a per-register countdown scoreboard covering ALU, load and multi-cycle (MUL) producers.
- Targets two consumer points: EX operands and ID branch comparator.
- Sits beside the ID stage; drives PC/IF_ID write enables, the ID_EX bubble and the IF_ID flush; keeps a stall statistics counter.

Parameters:
- NREG, 32, number of architectural registers (register 0 never tracked).
- REG_W, 5, register index width (clog2 NREG).
- CNT_W, 3, scoreboard counter width; every latency must be at most 2^CNT_W-1.
- ALU_EX_LAT, 0, stall cycles for an EX consumer of an ALU result.
- ALU_ID_LAT, 1, stall cycles for a branch consumer of an ALU result.
- LD_EX_LAT, 1, stall cycles for an EX consumer of a load.
- LD_ID_LAT, 2, stall cycles for a branch consumer of a load.
- MUL_LAT, 4, stall cycles for any consumer of a MUL result.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs  in  REG_W  ID source register rs
- id_rt  in  REG_W  ID source register rt
- id_use_rs  in  1  instruction reads rs
- id_use_rt  in  1  instruction reads rt
- id_is_branch  in  1  sources are consumed by the ID branch comparator
- id_wr_en  in  1  instruction writes a register
- id_wr_reg  in  REG_W  destination register
- id_wr_class  in  2  0=ALU, 1=LOAD, 2=MUL, 3=reserved (treated as MUL)
- pipe_freeze  in  1  global memory stall; whole pipeline holds
- branch_taken  in  1  ID branch resolved taken this cycle
- pc_write  out  1  PC update enable
- if_id_write  out  1  IF_ID register write enable
- id_ex_bubble  out  1  insert NOP into ID_EX
- if_id_flush  out  1  clear IF_ID (squash fall-through fetch)
- busy  out  1  any scoreboard counter nonzero
- stall_count  out  32  saturating count of hazard-stall cycles

Behaviour:
- State: two arrays per register, cnt_ex[r] and cnt_id[r], each CNT_W bits.
- Entry 0 of both arrays is hard-wired to 0.
- Reset (async, rst_n=0): all counters 0, stall_count=0.
- Reset output values: pc_write=1, if_id_write=1, id_ex_bubble=0, if_id_flush=0, busy=0.
- Source selection: src_cnt(r) = cnt_id[r] if id_is_branch, else cnt_ex[r].
- hazard = id_valid & ((id_use_rs & src_cnt(id_rs)!=0) | (id_use_rt & src_cnt(id_rt)!=0)).
- Outputs are combinational from current counters and inputs, evaluated in priority order:
  1. pipe_freeze=1: pc_write=0, if_id_write=0, id_ex_bubble=0, if_id_flush=0; counters and stall_count hold.
  2. hazard=1: pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=0. branch_taken is ignored because the operands are not valid. stall_count increments, saturating at 2^32-1.
  3. Otherwise: pc_write=1, if_id_write=1, id_ex_bubble=0, if_id_flush=branch_taken.
- Issue condition: issue = id_valid & !hazard & !pipe_freeze.
- Counter update at each posedge with pipe_freeze=0: every nonzero counter decrements by 1.
- Issue load: if issue & id_wr_en & id_wr_reg!=0, the destination entry loads max(old-1, L).
  - L for cnt_ex: ALU_EX_LAT, LD_EX_LAT or MUL_LAT by class.
  - L for cnt_id: ALU_ID_LAT, LD_ID_LAT or MUL_LAT by class.
  - max() covers a WAW hit on a longer-latency pending write.
- Latency meaning: a producer issuing at edge t with latency L stalls a dependent instruction in ID for exactly L cycles after t; the dependent issues at edge t+L+1.
- Simultaneous events:
  - A source equal to the destination issuing the same cycle is checked against the pre-update counter.
  - Branch-taken with issue: the branch itself issues and the fall-through is flushed.
- busy = OR of all counters.
- Reset mid-stall clears the scoreboard immediately and releases the stall asynchronously.

Test Plan:
- lw $2 issue, then add $4,$2,$5 -> 1 stall cycle (bubble=1, pc_write=0), add issues on the 2nd cycle; stall_count=1.
- add $1 then beq $1,$2 -> 1 stall; lw $1 then beq $1 -> 2 stalls; stall_count=3 overall.
- mul $3 (MUL_LAT=4) then or $6,$3,$0 -> 4 stall cycles; with pipe_freeze high for 2 of them -> 6 cycles total, counters frozen during the freeze, stall_count +4.
- Write to $0 followed by a reader of $0 -> no stall, busy stays 0.
- mul $7 then add $7 (WAW), then reader of $7 -> stall lasts until the mul counter expires, not the ALU latency.
- branch_taken=1 with no hazard -> if_id_flush=1; branch_taken=1 during hazard -> flush=0. Assert rst_n=0 mid-stall -> outputs return to reset values within the same cycle.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Countdown scoreboard hazard unit for the five-stage core: tracks pending writes per
// register and stalls ID consumers (EX operands or branch comparator) until results are usable.
module hazard_scoreboard #(
   parameter int NREG       = 32,
   parameter int REG_W      = 5,
   parameter int CNT_W      = 3,
   parameter int ALU_EX_LAT = 0,
   parameter int ALU_ID_LAT = 1,
   parameter int LD_EX_LAT  = 1,
   parameter int LD_ID_LAT  = 2,
   parameter int MUL_LAT    = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic             id_is_branch,
   input  logic             id_wr_en,
   input  logic [REG_W-1:0] id_wr_reg,
   input  logic [1:0]       id_wr_class,
   input  logic             pipe_freeze,
   input  logic             branch_taken,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             id_ex_bubble,
   output logic             if_id_flush,
   output logic             busy,
   output logic [31:0]      stall_count
);

   logic [CNT_W-1:0] cnt_ex [NREG];
   logic [CNT_W-1:0] cnt_id [NREG];
   logic [CNT_W-1:0] lat_ex;
   logic [CNT_W-1:0] lat_id;
   logic             rs_pending;
   logic             rt_pending;
   logic             hazard;
   logic             issue;

   function automatic logic [CNT_W-1:0] dec_sat(input logic [CNT_W-1:0] c);
      return (c != '0) ? c - 1'b1 : '0;
   endfunction

   function automatic logic [CNT_W-1:0] max_cnt(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
      return (a > b) ? a : b;
   endfunction

   always_comb begin
      lat_ex = CNT_W'(MUL_LAT);
      lat_id = CNT_W'(MUL_LAT);
      case (id_wr_class)
         2'd0: begin
            lat_ex = CNT_W'(ALU_EX_LAT);
            lat_id = CNT_W'(ALU_ID_LAT);
         end
         2'd1: begin
            lat_ex = CNT_W'(LD_EX_LAT);
            lat_id = CNT_W'(LD_ID_LAT);
         end
         default: ;
      endcase
   end

   // Branch sources resolve in ID, so they wait on the longer ID-side countdown.
   always_comb begin
      rs_pending = id_is_branch ? (cnt_id[id_rs] != '0) : (cnt_ex[id_rs] != '0);
      rt_pending = id_is_branch ? (cnt_id[id_rt] != '0) : (cnt_ex[id_rt] != '0);
      hazard     = id_valid & ((id_use_rs & rs_pending) | (id_use_rt & rt_pending));
      issue      = id_valid & ~hazard & ~pipe_freeze;
   end

   always_comb begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      id_ex_bubble = 1'b0;
      if_id_flush  = 1'b0;
      if (!rst_n) begin
         pc_write    = 1'b1;
         if_id_write = 1'b1;
      end else if (pipe_freeze) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
      end else if (hazard) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_bubble = 1'b1;
      end else begin
         if_id_flush = branch_taken;
      end
   end

   // Entry 0 is only ever cleared, so $0 can never report a pending write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NREG; r++) begin
            cnt_ex[r] <= '0;
            cnt_id[r] <= '0;
         end
      end else if (!pipe_freeze) begin
         for (int r = 1; r < NREG; r++) begin
            if (issue && id_wr_en && id_wr_reg == REG_W'(r)) begin
               cnt_ex[r] <= max_cnt(dec_sat(cnt_ex[r]), lat_ex);
               cnt_id[r] <= max_cnt(dec_sat(cnt_id[r]), lat_id);
            end else begin
               cnt_ex[r] <= dec_sat(cnt_ex[r]);
               cnt_id[r] <= dec_sat(cnt_id[r]);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_count <= '0;
      end else if (!pipe_freeze && hazard && stall_count != '1) begin
         stall_count <= stall_count + 32'd1;
      end
   end

   always_comb begin
      busy = 1'b0;
      for (int r = 0; r < NREG; r++) begin
         busy = busy | (cnt_ex[r] != '0) | (cnt_id[r] != '0);
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: a ready-time model predicts each cycle's outputs,
// which a separate monitor pops and compares on the falling edge.
module tb_hazard_scoreboard;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid;
   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic        id_use_rs;
   logic        id_use_rt;
   logic        id_is_branch;
   logic        id_wr_en;
   logic [4:0]  id_wr_reg;
   logic [1:0]  id_wr_class;
   logic        pipe_freeze;
   logic        branch_taken;
   logic        pc_write;
   logic        if_id_write;
   logic        id_ex_bubble;
   logic        if_id_flush;
   logic        busy;
   logic [31:0] stall_count;

   typedef struct {
      logic        pc_write;
      logic        if_id_write;
      logic        bubble;
      logic        flush;
      logic        busy;
      logic [31:0] stall;
   } exp_t;

   exp_t        exp_q[$];
   int          compared   = 0;
   int          mismatched = 0;
   int          pushed     = 0;
   int          popped     = 0;
   // Absolute tick (count of unfrozen edges) at which each register's result becomes usable.
   int          ready_ex[32];
   int          ready_id[32];
   int          now_tick;
   logic [31:0] stall_model;

   hazard_scoreboard dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .id_valid     (id_valid),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_use_rs    (id_use_rs),
      .id_use_rt    (id_use_rt),
      .id_is_branch (id_is_branch),
      .id_wr_en     (id_wr_en),
      .id_wr_reg    (id_wr_reg),
      .id_wr_class  (id_wr_class),
      .pipe_freeze  (pipe_freeze),
      .branch_taken (branch_taken),
      .pc_write     (pc_write),
      .if_id_write  (if_id_write),
      .id_ex_bubble (id_ex_bubble),
      .if_id_flush  (if_id_flush),
      .busy         (busy),
      .stall_count  (stall_count)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic bit pending(input int r, input bit br);
      if (r == 0) return 1'b0;
      return br ? (ready_id[r] > now_tick) : (ready_ex[r] > now_tick);
   endfunction

   function automatic bit modelBusy();
      for (int r = 1; r < 32; r++) begin
         if (ready_ex[r] > now_tick || ready_id[r] > now_tick) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic void clearModel();
      for (int r = 0; r < 32; r++) begin
         ready_ex[r] = 0;
         ready_id[r] = 0;
      end
      now_tick    = 0;
      stall_model = 32'd0;
   endfunction

   task automatic driveIdle();
      id_valid     = 1'b0;
      id_rs        = 5'd0;
      id_rt        = 5'd0;
      id_use_rs    = 1'b0;
      id_use_rt    = 1'b0;
      id_is_branch = 1'b0;
      id_wr_en     = 1'b0;
      id_wr_reg    = 5'd0;
      id_wr_class  = 2'd0;
      pipe_freeze  = 1'b0;
      branch_taken = 1'b0;
   endtask

   // Called at posedge+1: drive one cycle, predict outputs, then advance the model across the edge.
   task automatic applyStimulus(input bit v, input int rs, input int rt, input bit urs,
                                input bit urt, input bit br, input bit we, input int wr,
                                input int cls, input bit frz, input bit tk);
      exp_t e;
      bit   haz;
      int   lex;
      int   lid;
      id_valid     = v;
      id_rs        = 5'(rs);
      id_rt        = 5'(rt);
      id_use_rs    = urs;
      id_use_rt    = urt;
      id_is_branch = br;
      id_wr_en     = we;
      id_wr_reg    = 5'(wr);
      id_wr_class  = 2'(cls);
      pipe_freeze  = frz;
      branch_taken = tk;
      haz     = v && ((urs && pending(rs, br)) || (urt && pending(rt, br)));
      e.busy  = modelBusy();
      e.stall = stall_model;
      if (frz) begin
         e.pc_write = 1'b0; e.if_id_write = 1'b0; e.bubble = 1'b0; e.flush = 1'b0;
      end else if (haz) begin
         e.pc_write = 1'b0; e.if_id_write = 1'b0; e.bubble = 1'b1; e.flush = 1'b0;
      end else begin
         e.pc_write = 1'b1; e.if_id_write = 1'b1; e.bubble = 1'b0; e.flush = tk;
      end
      exp_q.push_back(e);
      pushed++;
      @(posedge clk);
      if (!frz) begin
         if (haz && stall_model != 32'hFFFF_FFFF) stall_model = stall_model + 32'd1;
         if (v && !haz && we && wr != 0) begin
            lex = (cls == 0) ? 0 : (cls == 1) ? 1 : 4;
            lid = (cls == 0) ? 1 : (cls == 1) ? 2 : 4;
            if (now_tick + 1 + lex > ready_ex[wr]) ready_ex[wr] = now_tick + 1 + lex;
            if (now_tick + 1 + lid > ready_id[wr]) ready_id[wr] = now_tick + 1 + lid;
         end
         now_tick++;
      end
      #1;
   endtask

   task automatic doReset();
      driveIdle();
      rst_n = 1'b0;
      clearModel();
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_pc_write", 32'(pc_write), 32'd1);
      checkOutput("reset_if_id_write", 32'(if_id_write), 32'd1);
      checkOutput("reset_bubble", 32'(id_ex_bubble), 32'd0);
      checkOutput("reset_flush", 32'(if_id_flush), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_stall_count", stall_count, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Hold a stalled consumer of rd, then pull reset partway through the cycle.
   task automatic resetMidStall(input int rd);
      exp_t e;
      id_valid  = 1'b1;
      id_rs     = 5'(rd);
      id_rt     = 5'd0;
      id_use_rs = 1'b1;
      id_use_rt = 1'b0;
      id_wr_en  = 1'b0;
      #1;
      checkOutput("pre_reset_bubble", 32'(id_ex_bubble), 32'd1);
      rst_n = 1'b0;
      clearModel();
      e.pc_write = 1'b1; e.if_id_write = 1'b1; e.bubble = 1'b0; e.flush = 1'b0;
      e.busy = 1'b0; e.stall = 32'd0;
      exp_q.push_back(e);
      pushed++;
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      driveIdle();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         popped++;
         checkOutput("pc_write", 32'(pc_write), 32'(e.pc_write));
         checkOutput("if_id_write", 32'(if_id_write), 32'(e.if_id_write));
         checkOutput("id_ex_bubble", 32'(id_ex_bubble), 32'(e.bubble));
         checkOutput("if_id_flush", 32'(if_id_flush), 32'(e.flush));
         checkOutput("busy", 32'(busy), 32'(e.busy));
         checkOutput("stall_count", stall_count, e.stall);
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int frz_pat[7];
      frz_pat = '{0, 1, 1, 0, 0, 0, 0};
      rst_n = 1'b1;
      driveIdle();
      #2;

      doReset();
      applyStimulus(1, 0, 0, 0, 0, 0, 1, 2, 1, 0, 0);
      repeat (2) applyStimulus(1, 2, 5, 1, 1, 0, 1, 4, 0, 0, 0);
      checkOutput("lw_add_stalls", stall_count, 32'd1);

      doReset();
      applyStimulus(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      repeat (2) applyStimulus(1, 1, 2, 1, 1, 1, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
      repeat (3) applyStimulus(1, 1, 2, 1, 1, 1, 0, 0, 0, 0, 0);
      checkOutput("branch_stalls", stall_count, 32'd3);

      doReset();
      applyStimulus(1, 0, 0, 0, 0, 0, 1, 3, 2, 0, 0);
      foreach (frz_pat[i]) applyStimulus(1, 3, 0, 1, 1, 0, 1, 6, 0, frz_pat[i] != 0, 0);
      checkOutput("mul_freeze_stalls", stall_count, 32'd4);

      applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 2, 0, 0);
      repeat (2) applyStimulus(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);

      applyStimulus(1, 0, 0, 0, 0, 0, 1, 7, 2, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0);
      repeat (5) applyStimulus(1, 7, 0, 1, 0, 0, 0, 0, 0, 0, 0);

      applyStimulus(1, 8, 9, 1, 1, 1, 0, 0, 0, 0, 1);
      applyStimulus(1, 0, 0, 0, 0, 0, 1, 10, 2, 0, 0);
      applyStimulus(1, 10, 9, 1, 1, 1, 0, 0, 0, 0, 1);

      applyStimulus(1, 0, 0, 0, 0, 0, 1, 11, 2, 0, 0);
      resetMidStall(11);

      for (int n = 0; n < 1500; n++) begin
         applyStimulus($urandom_range(0, 9) != 0, int'($urandom_range(0, 7)),
                       int'($urandom_range(0, 7)), $urandom_range(0, 2) != 0,
                       $urandom_range(0, 1) != 0, $urandom_range(0, 3) == 0,
                       $urandom_range(0, 9) < 7, int'($urandom_range(0, 7)),
                       int'($urandom_range(0, 3)), $urandom_range(0, 9) == 0,
                       $urandom_range(0, 2) == 0);
      end

      driveIdle();
      repeat (3) @(negedge clk);
      checkOutput("scoreboard_drain", 32'(popped), 32'(pushed));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
